// File: rtl/lane_rotator.sv
// lane_rotator: LANES x WIDTH circular register rotator with a start/busy/done
// handshake. Each ROTATE cycle moves every lane by one position at once, so
// each lane takes its neighbour's pre-edge value.
//
// Optional feature macro: LANE_ROTATOR_DIR_EN
//   defined   -> `dir` (0 = left, 1 = right) is latched at start.
//   undefined -> direction fixed to left; `dir` is ignored, and neither a
//                direction register nor a right-rotate path is built.
module lane_rotator #(
    parameter int WIDTH = 8,
    parameter int LANES = 3,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [WIDTH*LANES-1:0] load_data,
    input  logic                   start,
    input  logic [CNT_W-1:0]       count,
    input  logic                   dir,
    output logic [WIDTH*LANES-1:0] lanes_out,
    output logic                   busy,
    output logic                   done
);

    localparam int TOTAL_W = WIDTH * LANES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [TOTAL_W-1:0] lanes_q;
    logic [TOTAL_W-1:0] lanes_step;
    logic [CNT_W-1:0]   remaining;
    logic               busy_q;
    logic               done_q;

`ifdef LANE_ROTATOR_DIR_EN
    logic               dir_q;
`else
    logic               unused_dir;
    assign unused_dir = dir;
`endif

    // Left step: lane[i] <- lane[(i+1) mod LANES]. With lane 0 in the low
    // bits, this is a right rotate of the packed vector by one lane.
    function automatic logic [TOTAL_W-1:0] rot_left(input logic [TOTAL_W-1:0] v);
        return {v[WIDTH-1:0], v[TOTAL_W-1:WIDTH]};
    endfunction

`ifdef LANE_ROTATOR_DIR_EN
    // Right step: lane[i] <- lane[(i-1) mod LANES], i.e. the top lane
    // wraps into lane 0.
    function automatic logic [TOTAL_W-1:0] rot_right(input logic [TOTAL_W-1:0] v);
        return {v[TOTAL_W-WIDTH-1:0], v[TOTAL_W-1 -: WIDTH]};
    endfunction
`endif

    // Next lane contents for one rotation step in the latched direction.
    always_comb begin
        lanes_step = rot_left(lanes_q);
`ifdef LANE_ROTATOR_DIR_EN
        if (dir_q) begin
            lanes_step = rot_right(lanes_q);
        end
`endif
    end

    // Control FSM and lane registers; reset aborts any run and clears lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lanes_q   <= '0;
            remaining <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LANE_ROTATOR_DIR_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (load) begin
                        // load has priority; a simultaneous start is dropped
                        lanes_q <= load_data;
                    end else if (start) begin
                        if (count != '0) begin
                            remaining <= count;
`ifdef LANE_ROTATOR_DIR_EN
                            dir_q     <= dir;
`endif
                            busy_q    <= 1'b1;
                            state     <= ROTATE;
                        end else begin
                            // zero-length run: straight to the done pulse
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                ROTATE: begin
                    lanes_q   <= lanes_step;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign lanes_out = lanes_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lane_rotator.sv
// Directed testbench for lane_rotator (WIDTH=8, LANES=3, CNT_W=8).
// Packed lane values are written {lane2, lane1, lane0}.
module tb_lane_rotator;

    logic        clk;
    logic        rst;
    logic        load;
    logic [23:0] load_data;
    logic        start;
    logic [7:0]  count;
    logic        dir;
    logic [23:0] lanes_out;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    localparam logic [23:0] L617 = {8'd7, 8'd1, 8'd6}; // lanes {6,1,7}
    localparam logic [23:0] L176 = {8'd6, 8'd7, 8'd1}; // lanes {1,7,6}
    localparam logic [23:0] L761 = {8'd1, 8'd6, 8'd7}; // lanes {7,6,1}
    localparam logic [23:0] L999 = {8'd9, 8'd9, 8'd9};

    lane_rotator #(.WIDTH(8), .LANES(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .start     (start),
        .count     (count),
        .dir       (dir),
        .lanes_out (lanes_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic b, input logic d);
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    task automatic do_load(input logic [23:0] data);
        load      = 1'b1;
        load_data = data;
        tick();
        load      = 1'b0;
        load_data = '0;
    endtask

    task automatic do_start(input logic [7:0] n);
        start = 1'b1;
        count = n;
        tick();
        start = 1'b0;
        count = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        load        = 1'b0;
        load_data   = '0;
        start       = 1'b0;
        count       = '0;
        dir         = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("reset.lanes", {8'd0, lanes_out}, 32'd0);
        chk_ctl("reset", 1'b0, 1'b0);

        // Load {6,1,7}
        do_load(L617);
        chk("load.lanes", {8'd0, lanes_out}, {8'd0, L617});
        chk_ctl("load", 1'b0, 1'b0);

        // count=1 left
        do_start(8'd1);
        chk_ctl("c1.E0", 1'b1, 1'b0);
        chk("c1.E0.lanes", {8'd0, lanes_out}, {8'd0, L617});
        tick();
        chk("c1.E1.lanes", {8'd0, lanes_out}, {8'd0, L176});
        chk_ctl("c1.E1", 1'b0, 1'b1);
        tick();
        chk_ctl("c1.E2", 1'b0, 1'b0);

        // count=3 returns to the start contents
        do_load(L617);
        do_start(8'd3);
        chk_ctl("c3.E0", 1'b1, 1'b0);
        tick();
        chk_ctl("c3.E1", 1'b1, 1'b0);
        chk("c3.E1.lanes", {8'd0, lanes_out}, {8'd0, L176});
        tick();
        chk_ctl("c3.E2", 1'b1, 1'b0);
        tick();
        chk_ctl("c3.E3", 1'b0, 1'b1);
        chk("c3.E3.lanes", {8'd0, lanes_out}, {8'd0, L617});
        tick();
        chk_ctl("c3.E4", 1'b0, 1'b0);

        // count=0: done pulse right after start, busy never rises
        do_start(8'd0);
        chk_ctl("c0.E0", 1'b0, 1'b1);
        chk("c0.E0.lanes", {8'd0, lanes_out}, {8'd0, L617});
        tick();
        chk_ctl("c0.E1", 1'b0, 1'b0);
        chk("c0.E1.lanes", {8'd0, lanes_out}, {8'd0, L617});

        // dir=1, count=1
        dir = 1'b1;
        do_start(8'd1);
        dir = 1'b0;
        tick();
`ifdef LANE_ROTATOR_DIR_EN
        chk("dir1.lanes", {8'd0, lanes_out}, {8'd0, L761});
`else
        chk("dir1.lanes", {8'd0, lanes_out}, {8'd0, L176});
`endif
        chk_ctl("dir1.E1", 1'b0, 1'b1);
        tick();

        // count=5 with load/start pulsed while busy: both ignored
        do_load(L617);
        do_start(8'd5);
        tick();
        load      = 1'b1;
        load_data = L999;
        start     = 1'b1;
        count     = 8'd2;
        tick();
        load      = 1'b0;
        load_data = '0;
        start     = 1'b0;
        count     = '0;
        chk("c5.E2.lanes", {8'd0, lanes_out}, {8'd0, L761});
        chk_ctl("c5.E2", 1'b1, 1'b0);
        tick();
        tick();
        chk_ctl("c5.E4", 1'b1, 1'b0);
        tick();
        chk_ctl("c5.E5", 1'b0, 1'b1);
        chk("c5.E5.lanes", {8'd0, lanes_out}, {8'd0, L761});
        tick();
        chk_ctl("c5.E6", 1'b0, 1'b0);
        chk("c5.E6.lanes", {8'd0, lanes_out}, {8'd0, L761});

        // Reset during the second step of a count=4 run
        do_load(L617);
        do_start(8'd4);
        tick();
        chk("rst4.E1.lanes", {8'd0, lanes_out}, {8'd0, L176});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst4.lanes", {8'd0, lanes_out}, 32'd0);
        chk_ctl("rst4", 1'b0, 1'b0);
        tick();
        chk_ctl("rst4.idle", 1'b0, 1'b0);
        chk("rst4.idle.lanes", {8'd0, lanes_out}, 32'd0);

        // Normal operation after the aborted run
        do_load(L617);
        chk("post.load", {8'd0, lanes_out}, {8'd0, L617});
        do_start(8'd2);
        chk_ctl("post.E0", 1'b1, 1'b0);
        tick();
        tick();
        chk("post.E2.lanes", {8'd0, lanes_out}, {8'd0, L761});
        chk_ctl("post.E2", 1'b0, 1'b1);
        tick();
        chk_ctl("post.E3", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
